wb_stage: RTL
=============

Name: wb_stage

Overview:
Writeback stage of the 5-stage MIPS pipeline. It is the producer end of the ID-stage register-file write port (wb_reg_write/wb_rd/wb_wd).
- Holds the MEM/WB pipeline register.
- Waits for variable-latency data-memory load responses.
- Formats load data (byte/half/word, signed/unsigned).
- Drives the regfile write, with a stall back to upstream stages while a load is outstanding.

Parameters:
- DW, 32, datapath width; only 32 is supported.
- RW, 5, register-index width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- mem_valid  in  1  MEM stage presents an instruction (0 = bubble).
- mem_reg_write  in  1  instruction writes a register.
- mem_rd  in  RW  destination register.
- mem_alu_result  in  DW  ALU/link/lui result; for loads, the effective address.
- mem_is_load  in  1  instruction is a load.
- mem_load_type  in  3  load_type_e encoding.
- dmem_rvalid  in  1  load response valid (single-cycle pulse per request).
- dmem_rdata  in  DW  raw aligned word from data memory.
- wb_stall  out  1  stage busy; upstream must hold, and MEM/WB does not capture.
- wb_reg_write  out  1  regfile write enable.
- wb_rd  out  RW  regfile write address.
- wb_wd  out  DW  regfile write data.

Behaviour:
- Reset (async assert, sync-released by top):
  - pipe valid=0, state=IDLE, ld_buf=0.
  - Outputs wb_stall=0, wb_reg_write=0, wb_rd=0, wb_wd=0.
- Pipe register: captures all mem_* fields when wb_stall=0, and holds while wb_stall=1. A bubble (mem_valid=0) captures valid=0.
- Address bits: addr_lo = pipe alu_result[1:0].
- FSM states: IDLE, WAIT, COMMIT.
  - IDLE, non-load valid: wb_reg_write = reg_write & (rd!=0); wb_wd = alu_result; wb_stall=0. This is zero extra latency (write occurs in the cycle the instruction is in WB).
  - IDLE, valid load: wb_stall=1, wb_reg_write=0.
    - dmem_rvalid=1 this cycle: latch formatted data into ld_buf, go to COMMIT.
    - Otherwise: go to WAIT.
  - WAIT: wb_stall=1, wb_reg_write=0. On dmem_rvalid, latch formatted data into ld_buf and go to COMMIT.
  - COMMIT: wb_stall=0; wb_wd = ld_buf; wb_reg_write = reg_write & (rd!=0). Go to IDLE; the next instruction is captured on the same edge.
- Load latency: minimum 2 cycles in WB (rvalid in the first cycle); 1 + N otherwise.
- Load formatting (little-endian):
  - LT_W: word unchanged.
  - LT_B / LT_BU: byte addr_lo, sign- or zero-extended.
  - LT_H / LT_HU: half selected by addr_lo[1] (addr_lo[0] ignored), sign- or zero-extended.
  - Undefined encodings: treated as LT_W.
- rd==0: wb_reg_write is never asserted. wb_rd and wb_wd still reflect the pipe contents.
- Invalid slot: wb_reg_write=0; wb_rd and wb_wd hold their last values.
- dmem_rvalid with no load pending (IDLE non-load/bubble, or COMMIT): ignored.
- Reset mid-load: the pending load is dropped. A late rvalid after reset is ignored by the rule above.

Optional Feature:
- Macro WB_PERF_CNT_EN.
- Defined: adds outputs perf_retired[31:0] and perf_ld_wait[31:0], both reset to 0 and wrapping at 2^32.
  - perf_retired increments once per valid instruction leaving WB: IDLE for non-loads, COMMIT for loads.
  - perf_ld_wait increments each cycle in WAIT.
- Undefined: ports and counters are absent. Functional behaviour is otherwise identical.

Decomposition:
- Package wb_pkg holds:
  - typedef enum logic[2:0] load_type_e: LT_W=0, LT_B=1, LT_BU=2, LT_H=3, LT_HU=4.
  - typedef enum wb_state_e: IDLE, WAIT, COMMIT.
- One combinational sub-module, load_align: inputs rdata, addr_lo, load_type; output formatted word.

Test Plan:
- Non-load: valid, rd=8, reg_write=1, alu=0x1234_5678 → same cycle wb_reg_write=1, wb_rd=8, wb_wd=0x1234_5678, wb_stall=0.
- rd=0 write: alu=0xFFFF_FFFF → wb_reg_write=0; next instruction proceeds without stall.
- LB: addr_lo=2, rdata=0x0080_0000, rvalid in the first WB cycle → stall 1 cycle; COMMIT wb_wd=0xFFFF_FF80. Same access as LBU → 0x0000_0080.
- LHU: addr=0x...2, rdata=0xBEEF_0000, rvalid after 3 cycles → wb_stall high 4 cycles; then wb_wd=0x0000_BEEF; MEM/WB unchanged throughout the stall.
- Stray rvalid with a bubble, then rst_n pulsed low while in WAIT → no write; state IDLE; outputs zero; a subsequent rvalid is ignored.
- WB_PERF_CNT_EN: 3 ALU ops plus 1 load with 2 wait cycles → perf_retired=4, perf_ld_wait=2.

Source files
------------

// File: rtl/wb_stage_pkg.sv
// ----------------------------------------------------------------------------
// wb_pkg : shared types and helpers for the MIPS writeback stage.
//   load_type_e : load width/sign encoding carried from MEM into WB.
//   wb_state_e  : writeback FSM states (IDLE, WAIT, COMMIT).
//   ext8/ext16  : sign- or zero-extension helpers used by load formatting.
// ----------------------------------------------------------------------------
package wb_pkg;

  localparam int unsigned WB_DW = 32;

  typedef enum logic [2:0] {
    LT_W  = 3'd0,
    LT_B  = 3'd1,
    LT_BU = 3'd2,
    LT_H  = 3'd3,
    LT_HU = 3'd4
  } load_type_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    COMMIT = 2'd2
  } wb_state_e;

  // Extend a byte to a full word; sgn selects sign extension.
  function automatic logic [WB_DW-1:0] ext8(input logic [7:0] b, input logic sgn);
    return {{(WB_DW-8){sgn & b[7]}}, b};
  endfunction

  // Extend a halfword to a full word; sgn selects sign extension.
  function automatic logic [WB_DW-1:0] ext16(input logic [15:0] h, input logic sgn);
    return {{(WB_DW-16){sgn & h[15]}}, h};
  endfunction

endpackage

// File: rtl/wb_stage_load_align.sv
// ----------------------------------------------------------------------------
// load_align : combinational little-endian load formatter.
//   rdata_i     : raw aligned word returned by data memory
//   addr_lo_i   : low two bits of the effective address
//   load_type_i : load_type_e encoding (undefined codes behave as LT_W)
//   data_o      : word to be written to the register file
// ----------------------------------------------------------------------------
module load_align
  import wb_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [2:0]  load_type_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Select lane byte/half, then extend according to the load type.
  always_comb begin
    byte_s = 8'h00;
    half_s = 16'h0000;
    data_o = rdata_i;

    case (addr_lo_i)
      2'd0:    byte_s = rdata_i[7:0];
      2'd1:    byte_s = rdata_i[15:8];
      2'd2:    byte_s = rdata_i[23:16];
      2'd3:    byte_s = rdata_i[31:24];
      default: byte_s = rdata_i[7:0];
    endcase

    // Halfword lane comes from addr bit 1 only; bit 0 is ignored.
    if (addr_lo_i[1]) begin
      half_s = rdata_i[31:16];
    end else begin
      half_s = rdata_i[15:0];
    end

    case (load_type_i)
      LT_B:    data_o = ext8(byte_s, 1'b1);
      LT_BU:   data_o = ext8(byte_s, 1'b0);
      LT_H:    data_o = ext16(half_s, 1'b1);
      LT_HU:   data_o = ext16(half_s, 1'b0);
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// ----------------------------------------------------------------------------
// wb_stage : writeback stage of the 5-stage MIPS pipeline.
// Holds the MEM/WB register, waits for variable-latency load responses,
// formats load data and drives the register-file write port.
//
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   mem_valid .. mem_load_type : instruction presented by MEM (captured when
//                                wb_stall is low)
//   dmem_rvalid, dmem_rdata    : single-cycle load response from data memory
//   wb_stall                   : stage busy, upstream holds
//   wb_reg_write/wb_rd/wb_wd   : register-file write port
//
// Optional: define WB_PERF_CNT_EN to add perf_retired / perf_ld_wait
// 32-bit wrapping counters (retired instructions, load-wait cycles).
// ----------------------------------------------------------------------------
module wb_stage
  import wb_pkg::*;
#(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          mem_valid,
  input  logic          mem_reg_write,
  input  logic [RW-1:0] mem_rd,
  input  logic [DW-1:0] mem_alu_result,
  input  logic          mem_is_load,
  input  logic [2:0]    mem_load_type,
  input  logic          dmem_rvalid,
  input  logic [DW-1:0] dmem_rdata,
  output logic          wb_stall,
  output logic          wb_reg_write,
  output logic [RW-1:0] wb_rd,
  output logic [DW-1:0] wb_wd
`ifdef WB_PERF_CNT_EN
  ,
  output logic [31:0]   perf_retired,
  output logic [31:0]   perf_ld_wait
`endif
);

  // MEM/WB pipeline register
  logic          valid_q;
  logic          reg_write_q;
  logic [RW-1:0] rd_q;
  logic [DW-1:0] alu_q;
  logic          is_load_q;
  logic [2:0]    load_type_q;

  // FSM and load buffer
  wb_state_e     state_q, state_d;
  logic [DW-1:0] ld_buf_q, ld_buf_d;

  // Last driven rd/wd, shown again while the slot is a bubble
  logic [RW-1:0] hold_rd_q;
  logic [DW-1:0] hold_wd_q;

  logic          stall_s;
  logic          we_s;
  logic [RW-1:0] rd_s;
  logic [DW-1:0] wd_s;
  logic [DW-1:0] fmt_s;
  logic          rd_nz_s;

  load_align u_load_align (
    .rdata_i     (dmem_rdata),
    .addr_lo_i   (alu_q[1:0]),
    .load_type_i (load_type_q),
    .data_o      (fmt_s)
  );

  assign rd_nz_s = (rd_q != {RW{1'b0}});

  // MEM/WB register: capture everything (including bubbles) unless stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q     <= 1'b0;
      reg_write_q <= 1'b0;
      rd_q        <= {RW{1'b0}};
      alu_q       <= {DW{1'b0}};
      is_load_q   <= 1'b0;
      load_type_q <= 3'd0;
    end else if (!stall_s) begin
      valid_q     <= mem_valid;
      reg_write_q <= mem_reg_write;
      rd_q        <= mem_rd;
      alu_q       <= mem_alu_result;
      is_load_q   <= mem_is_load;
      load_type_q <= mem_load_type;
    end else begin
      valid_q     <= valid_q;
      reg_write_q <= reg_write_q;
      rd_q        <= rd_q;
      alu_q       <= alu_q;
      is_load_q   <= is_load_q;
      load_type_q <= load_type_q;
    end
  end

  // FSM state, load buffer and bubble-hold registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ld_buf_q  <= {DW{1'b0}};
      hold_rd_q <= {RW{1'b0}};
      hold_wd_q <= {DW{1'b0}};
    end else begin
      state_q   <= state_d;
      ld_buf_q  <= ld_buf_d;
      hold_rd_q <= rd_s;
      hold_wd_q <= wd_s;
    end
  end

  // Next-state, stall and write-enable decode. rvalid is only consumed
  // while a load sits in IDLE or WAIT; anywhere else it is ignored.
  always_comb begin
    state_d  = state_q;
    ld_buf_d = ld_buf_q;
    stall_s  = 1'b0;
    we_s     = 1'b0;

    case (state_q)
      IDLE: begin
        if (valid_q && is_load_q) begin
          stall_s = 1'b1;
          if (dmem_rvalid) begin
            ld_buf_d = fmt_s;
            state_d  = COMMIT;
          end else begin
            state_d  = WAIT;
          end
        end else begin
          we_s    = valid_q & reg_write_q & rd_nz_s;
          state_d = IDLE;
        end
      end
      WAIT: begin
        stall_s = 1'b1;
        if (dmem_rvalid) begin
          ld_buf_d = fmt_s;
          state_d  = COMMIT;
        end else begin
          state_d  = WAIT;
        end
      end
      COMMIT: begin
        we_s    = valid_q & reg_write_q & rd_nz_s;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Write address/data: pipe contents for a valid slot, last values otherwise.
  always_comb begin
    rd_s = hold_rd_q;
    wd_s = hold_wd_q;
    if (valid_q) begin
      rd_s = rd_q;
      if (state_q == COMMIT) begin
        wd_s = ld_buf_q;
      end else begin
        wd_s = alu_q;
      end
    end else begin
      rd_s = hold_rd_q;
      wd_s = hold_wd_q;
    end
  end

  assign wb_stall     = stall_s;
  assign wb_reg_write = we_s;
  assign wb_rd        = rd_s;
  assign wb_wd        = wd_s;

`ifdef WB_PERF_CNT_EN
  logic [31:0] perf_retired_q;
  logic [31:0] perf_ld_wait_q;
  logic        retire_s;

  // A load retires in COMMIT; everything else retires from IDLE.
  assign retire_s = ((state_q == IDLE) && valid_q && !is_load_q) ||
                    (state_q == COMMIT);

  // Wrapping retirement and load-wait counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_retired_q <= 32'd0;
      perf_ld_wait_q <= 32'd0;
    end else begin
      if (retire_s) begin
        perf_retired_q <= perf_retired_q + 32'd1;
      end else begin
        perf_retired_q <= perf_retired_q;
      end
      if (state_q == WAIT) begin
        perf_ld_wait_q <= perf_ld_wait_q + 32'd1;
      end else begin
        perf_ld_wait_q <= perf_ld_wait_q;
      end
    end
  end

  assign perf_retired = perf_retired_q;
  assign perf_ld_wait = perf_ld_wait_q;
`endif

endmodule
